// File: rtl/rs_pkg.sv
// Shared GF(16) definitions for the RS(15,9) receive path: field constants,
// alpha power table, decoder state encoding and a multiply-by-alpha helper.
package rs_pkg;

  localparam int SYM_W  = 4;
  localparam int N_SYM  = 15;
  localparam int K_SYM  = 9;
  localparam int N_SYND = N_SYM - K_SYM;

  localparam logic [SYM_W:0] PRIM_POLY = 5'b10011;

  localparam logic [SYM_W-1:0] ALPHA_POW [0:N_SYM-1] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Multiply by alpha: shift up one power and fold x^4 back via x^4 = x + 1.
  function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
    logic [SYM_W-1:0] fold;
    fold = a[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0;
    return {a[SYM_W-2:0], 1'b0} ^ fold;
  endfunction

endpackage

// File: rtl/rs_syndrome_decoder_gf16_mul_const.sv
// Combinational GF(16) multiply by the constant alpha^POWER; the repeated
// xtime unrolls at elaboration into a small XOR network.
module gf16_mul_const
  import rs_pkg::*;
#(
  parameter int POWER = 1
) (
  input  logic [SYM_W-1:0] a_i,
  output logic [SYM_W-1:0] p_o
);

  logic [SYM_W-1:0] acc;

  always_comb begin
    acc = a_i;
    for (int i = 0; i < POWER; i++) begin
      acc = gf_xtime(acc);
    end
  end

  assign p_o = acc;

endmodule

// File: rtl/rs_syndrome_decoder.sv
// RS(15,9) syndrome front end: serial Horner evaluation of S1..S6, one symbol
// per clock; start-to-done 16 clocks, one word per 17, starts ignored while busy.
module rs_syndrome_decoder
  import rs_pkg::*;
#(
  parameter int N_SYM = 15,
  parameter int K_SYM = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_SYM*SYM_W-1:0]           codeWord,
  input  logic                             decodeCodeWord,
  output logic                             decoderBusy,
  output logic                             decodeDone,
  output logic                             errorDetected,
  output logic [(N_SYM-K_SYM)*SYM_W-1:0]   syndromesPacked,
  output logic [K_SYM*SYM_W-1:0]           messageOut
);

  localparam int CW_W  = N_SYM * SYM_W;
  localparam int MSG_W = K_SYM * SYM_W;
  localparam int SYN_W = (N_SYM - K_SYM) * SYM_W;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [CW_W-1:0]   cw_q;
  logic [CW_W-1:0]   cw_d;
  logic [SYN_W-1:0]  syn_q;
  logic [SYN_W-1:0]  syn_d;
  logic [SYM_W-1:0]  sym_in;

  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [SYN_W-1:0]  synd_out_q;
  logic [MSG_W-1:0]  msg_q;

  // The capture register rotates by one symbol per ACCUM cycle; after all
  // N_SYM rotations it is back to the original word, so the message field
  // can be taken from it on the final step without a second copy.
  assign sym_in = cw_q[CW_W-1 -: SYM_W];
  assign cw_d   = {cw_q[CW_W-SYM_W-1:0], cw_q[CW_W-1 -: SYM_W]};

  for (genvar j = 0; j < N_SYND; j++) begin : g_synd
    logic [SYM_W-1:0] prod;

    gf16_mul_const #(
      .POWER (j + 1)
    ) u_mul (
      .a_i (syn_q[SYM_W*j +: SYM_W]),
      .p_o (prod)
    );

    assign syn_d[SYM_W*j +: SYM_W] = prod ^ sym_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cw_q       <= '0;
      syn_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      synd_out_q <= '0;
      msg_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (decodeCodeWord) begin
            cw_q    <= codeWord;
            syn_q   <= '0;
            cnt_q   <= 4'(N_SYM - 1);
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          cw_q  <= cw_d;
          syn_q <= syn_d;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            synd_out_q <= syn_d;
            msg_q      <= cw_d[CW_W-1 -: MSG_W];
            err_q      <= |syn_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign decoderBusy     = busy_q;
  assign decodeDone      = done_q;
  assign errorDetected   = err_q;
  assign syndromesPacked = synd_out_q;
  assign messageOut      = msg_q;

endmodule

// File: tb/tb_rs_syndrome_decoder.sv
// Directed bench for rs_syndrome_decoder: known error patterns, encoder
// loopback, ignored restarts and mid-decode reset.
module tb_rs_syndrome_decoder;

  logic        clk;
  logic        rst_n;
  logic [59:0] codeWord;
  logic        decodeCodeWord;
  logic        decoderBusy;
  logic        decodeDone;
  logic        errorDetected;
  logic [23:0] syndromesPacked;
  logic [35:0] messageOut;

  int n_checks;
  int n_fail;

  rs_syndrome_decoder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .codeWord        (codeWord),
    .decodeCodeWord  (decodeCodeWord),
    .decoderBusy     (decoderBusy),
    .decodeDone      (decodeDone),
    .errorDetected   (errorDetected),
    .syndromesPacked (syndromesPacked),
    .messageOut      (messageOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  // Systematic encoder: c(x) = m(x)x^6 + (m(x)x^6 mod g(x)), g = prod (x + alpha^j), j=1..6.
  function automatic logic [59:0] rs_encode(input logic [35:0] msg);
    logic [3:0]  g   [0:6];
    logic [3:0]  rem [0:5];
    logic [3:0]  root;
    logic [3:0]  fb;
    logic [59:0] cw;
    for (int i = 0; i < 7; i++) g[i] = 4'h0;
    g[0] = 4'h1;
    root = 4'h2;
    for (int j = 1; j <= 6; j++) begin
      for (int i = 6; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], root);
      g[0] = gmul(g[0], root);
      root = gmul(root, 4'h2);
    end
    for (int i = 0; i < 6; i++) rem[i] = 4'h0;
    for (int i = 8; i >= 0; i--) begin
      fb = msg[4*i +: 4] ^ rem[5];
      for (int t = 5; t >= 1; t--) rem[t] = rem[t-1] ^ gmul(fb, g[t]);
      rem[0] = gmul(fb, g[0]);
    end
    cw = {msg, 24'h0};
    for (int t = 0; t < 6; t++) cw[4*t +: 4] = rem[t];
    return cw;
  endfunction

  // One decode over a fixed 24-cycle window. Cycle 1 is the cycle right after
  // the start edge. Optional extra start pulses and a one-cycle reset.
  task automatic decode(input logic [59:0] cw, input int pulse_a, input int pulse_b,
                        input int rst_cyc, output int lat, output int ndone,
                        output logic busy_at_done);
    lat          = -1;
    ndone        = 0;
    busy_at_done = 1'b1;
    @(negedge clk);
    codeWord       = cw;
    decodeCodeWord = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_after_start", 64'(decoderBusy), 64'd1);
        chk("err_clear_at_start", 64'(errorDetected), 64'd0);
        codeWord = {28'($urandom), 32'($urandom)};
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        chk("rst_busy", 64'(decoderBusy), 64'd0);
        chk("rst_done", 64'(decodeDone), 64'd0);
        chk("rst_err", 64'(errorDetected), 64'd0);
        chk("rst_synd", 64'(syndromesPacked), 64'd0);
        chk("rst_msg", 64'(messageOut), 64'd0);
        rst_n = 1'b1;
      end
      if (decodeDone) begin
        ndone++;
        if (lat < 0) begin
          lat          = cyc;
          busy_at_done = decoderBusy;
        end
      end
      decodeCodeWord = (cyc == pulse_a || cyc == pulse_b);
      if (rst_cyc > 0 && cyc == rst_cyc) rst_n = 1'b0;
    end
    decodeCodeWord = 1'b0;
  endtask

  logic [59:0] cw_a;
  logic [59:0] cw_b;
  int          lat;
  int          ndone;
  logic        busy_d;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    codeWord       = 60'h0;
    decodeCodeWord = 1'b0;
    cw_a           = rs_encode(36'h87);
    cw_b           = rs_encode(36'hE0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(decoderBusy), 64'd0);
    chk("reset_done", 64'(decodeDone), 64'd0);
    chk("reset_err", 64'(errorDetected), 64'd0);
    chk("reset_synd", 64'(syndromesPacked), 64'd0);
    chk("reset_msg", 64'(messageOut), 64'd0);
    rst_n = 1'b1;

    decode(60'h0, 0, 0, 0, lat, ndone, busy_d);
    chk("zero_latency", 64'(lat), 64'd16);
    chk("zero_ndone", 64'(ndone), 64'd1);
    chk("zero_busy_at_done", 64'(busy_d), 64'd0);
    chk("zero_synd", 64'(syndromesPacked), 64'h0);
    chk("zero_err", 64'(errorDetected), 64'd0);
    chk("zero_msg", 64'(messageOut), 64'h0);

    decode(60'h1, 0, 0, 0, lat, ndone, busy_d);
    chk("c0_latency", 64'(lat), 64'd16);
    chk("c0_synd", 64'(syndromesPacked), 64'h111111);
    chk("c0_err", 64'(errorDetected), 64'd1);

    decode(60'h10, 0, 0, 0, lat, ndone, busy_d);
    chk("c1_synd", 64'(syndromesPacked), 64'hC63842);
    chk("c1_err", 64'(errorDetected), 64'd1);
    chk("c1_msg", 64'(messageOut), 64'h0);
    repeat (4) @(negedge clk);
    chk("idle_hold_synd", 64'(syndromesPacked), 64'hC63842);
    chk("idle_hold_err", 64'(errorDetected), 64'd1);

    decode(cw_a, 0, 0, 0, lat, ndone, busy_d);
    chk("loopA_latency", 64'(lat), 64'd16);
    chk("loopA_synd", 64'(syndromesPacked), 64'h0);
    chk("loopA_err", 64'(errorDetected), 64'd0);
    chk("loopA_msg", 64'(messageOut), 64'h87);

    decode(cw_b, 0, 0, 0, lat, ndone, busy_d);
    chk("loopB_synd", 64'(syndromesPacked), 64'h0);
    chk("loopB_err", 64'(errorDetected), 64'd0);
    chk("loopB_msg", 64'(messageOut), 64'hE0);

    // Bit 40 is bit 0 of c10: syndromes are alpha^(10j).
    decode(cw_b ^ (60'h1 << 40), 0, 0, 0, lat, ndone, busy_d);
    chk("flip40_err", 64'(errorDetected), 64'd1);
    chk("flip40_synd", 64'(syndromesPacked), 64'h167167);
    chk("flip40_msg", 64'(messageOut), 64'h100E0);

    decode(60'h1, 0, 0, 8, lat, ndone, busy_d);
    chk("rst_mid_ndone", 64'(ndone), 64'd0);

    decode(cw_a, 0, 0, 0, lat, ndone, busy_d);
    chk("after_rst_latency", 64'(lat), 64'd16);
    chk("after_rst_synd", 64'(syndromesPacked), 64'h0);
    chk("after_rst_msg", 64'(messageOut), 64'h87);

    decode(60'h10, 5, 15, 0, lat, ndone, busy_d);
    chk("ignore_ndone", 64'(ndone), 64'd1);
    chk("ignore_latency", 64'(lat), 64'd16);
    chk("ignore_synd", 64'(syndromesPacked), 64'hC63842);
    chk("ignore_err", 64'(errorDetected), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_decoder.md
Name: rs_syndrome_decoder

Overview:
- Receive-side front end for the RS(15,9) GF(16) link. Accepts one 60-bit received codeword, as produced by encodingContV2.
- Computes the six syndromes S1..S6 serially (Horner, one symbol per clock), flags whether any error is present, and returns the systematic message field.
- Output feeds the later error-locator/correction stage; zero syndromes mean the message can be used directly.

Parameters:
- N_SYM, 15, codeword length in 4-bit symbols.
- K_SYM, 9, message length in symbols. N_SYM-K_SYM = 6 = number of syndromes.
- Only the defaults are supported; the parameters exist for width derivation only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- codeWord  in  60  received codeword. Bits [4k+3:4k] hold coefficient c_k; c14 is in [59:56].
- decodeCodeWord  in  1  start strobe; sampled only in IDLE.
- decoderBusy  out  1  high while a decode is in progress.
- decodeDone  out  1  one-cycle pulse when the results are valid.
- errorDetected  out  1  high if any syndrome is nonzero; valid from decodeDone, held until the next start.
- syndromesPacked  out  24  S_j in bits [4j-1:4j-4]: S1 in [3:0], S6 in [23:20].
- messageOut  out  36  codeWord[59:24] of the captured word; messageOut[3:0] is the X^0 message coefficient.

Behaviour:
- Field and code:
  - GF(16), primitive polynomial x^4+x+1, alpha = 4'h2.
  - Symbol bit 3 is the alpha^3 coefficient, so alpha^3 = 4'h8, alpha^10 = 4'h7 and alpha^11 = 4'hE.
  - The code is systematic with c(x) = m(x)·x^6 + r(x), so parity occupies codeWord[23:0].
  - Syndromes are S_j = c(alpha^j) for j = 1..6.
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: decoderBusy, decodeDone, errorDetected, syndromesPacked = 24'h0 and messageOut = 36'h0.
  - Internal registers (capture register, accumulators, counter) are cleared.
  - Reset applied mid-decode aborts the decode, and no decodeDone is issued.
- IDLE:
  - decodeCodeWord high at an edge captures codeWord into a shift register and clears the accumulators S1..S6 to 0.
  - It also loads the symbol counter with 14 and moves to ACCUM.
  - decoderBusy goes high in the following cycle.
- ACCUM:
  - Each cycle, for every j: S_j <= S_j·alpha^j XOR c_k, where k = counter value (symbols processed c14 first, down to c0).
  - The multiplications are constant multiplications (XOR networks). No general multiplier is used.
  - The counter decrements each cycle. The transition to DONE happens on the cycle that consumes c0.
  - This gives exactly 15 ACCUM cycles.
- DONE:
  - Lasts one cycle, with decodeDone = 1 and decoderBusy = 0.
  - syndromesPacked, messageOut and errorDetected are registered and valid in this cycle. errorDetected is the OR-reduce of all 24 syndrome bits.
  - The state returns to IDLE on the next edge.
- Latency: the start edge to the decodeDone cycle is 16 clocks. Throughput is one codeword per 17 clocks.
- Handshake and hold rules:
  - decodeCodeWord is ignored in ACCUM and DONE; no queueing.
  - The codeWord input may change freely after the start edge.
  - Outputs hold their values in IDLE until the next accepted start. At that start, errorDetected clears to 0 and syndromesPacked and messageOut keep their old values until DONE.
- Simultaneous rst_n low and decodeCodeWord high: reset wins.

Decomposition:
- Package rs_pkg:
  - SYM_W = 4, N_SYM = 15, K_SYM = 9, N_SYND = 6.
  - PRIM_POLY = 5'b10011.
  - alpha power table ALPHA_POW[0:14].
  - State enum {IDLE, ACCUM, DONE}.
- Sub-module gf16_mul_const: combinational, parameter POWER, output = input·alpha^POWER. It is instantiated six times (POWER = 1..6).
- The same sub-module will be reused by the future encoder refactor and the Chien-search stage.

Test Plan:
- All-zero codeword, start -> decodeDone exactly 16 clocks after the start edge; syndromesPacked = 24'h000000, errorDetected = 0, messageOut = 0.
- codeWord = 60'h1 (error e = 1 at c0) -> syndromesPacked = 24'h111111, errorDetected = 1.
- codeWord = 60'h10 (error at c1) -> S1..S6 = 2, 4, 8, 3, 6, C, i.e. syndromesPacked = 24'hC63842, errorDetected = 1.
- Loopback: encodingContV2 encodes the message 36'h87 (alpha^3·X + alpha^10) and the message 36'hE0 (alpha^11·X).
  - For each codeword -> syndromesPacked = 0, errorDetected = 0, messageOut equal to the original message.
  - Then flip bit 40 of the second codeword -> errorDetected = 1.
- Second decodeCodeWord pulse at clocks 5 and 15 of an ACCUM -> ignored. The result matches the first word only, with a single decodeDone.
- rst_n low for one cycle at ACCUM clock 8 -> all outputs 0 next cycle and no decodeDone. A fresh start afterwards yields correct results.
